// File: rtl/count_pkg.sv
// count_pkg: shared state enum, count width and prescaler width helper for the count sequencer
package count_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  localparam int COUNT_W = 5;
  localparam int DEF_MAX_COUNT = 19;
  function automatic int presc_w(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction
endpackage

// File: rtl/count_seq_ctrl_tick_prescaler.sv
// tick_prescaler: free-running divider that pulses tick every TICK_DIV enabled cycles
module tick_prescaler
  import count_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = presc_w(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  logic [W-1:0] cnt;
  assign tick = en && (cnt == LAST);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: run/pause sequencer for the 0..MAX_COUNT count; COUNT_SEQ_AUTO_STOP_EN makes it saturate and stop instead of wrap
module count_seq_ctrl
  import count_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MAX_COUNT = DEF_MAX_COUNT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               clear,
  input  logic               dir,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               step,
  output logic               wrap
);
  localparam logic [COUNT_W-1:0] MAXC = COUNT_W'(MAX_COUNT);
  state_t state, state_n;
  logic [COUNT_W-1:0] count_n;
  logic step_n, wrap_n, tick, at_end;
`ifdef COUNT_SEQ_AUTO_STOP_EN
  logic near;
`endif
  // clear also flushes partial prescaler progress
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk (clk),
    .rst (rst | clear),
    .en  (state == RUN),
    .tick(tick)
  );
  assign running = (state == RUN);
  assign at_end = dir ? (count == '0) : (count == MAXC);
`ifdef COUNT_SEQ_AUTO_STOP_EN
  assign near = dir ? (count == COUNT_W'(1)) : (count == MAXC - COUNT_W'(1));
`endif
  always_comb begin
    state_n = state;
    count_n = count;
    step_n = 1'b0;
    wrap_n = 1'b0;
    if (clear) begin
      state_n = IDLE;
      count_n = '0;
    end else begin
      state_n = start ? RUN : (pause && state == RUN) ? PAUSED : state;
      if (tick) begin
`ifdef COUNT_SEQ_AUTO_STOP_EN
        step_n = !at_end;
        wrap_n = near;
        count_n = at_end ? count : dir ? count - COUNT_W'(1) : count + COUNT_W'(1);
        state_n = (at_end || near) ? IDLE : state_n;
`else
        step_n = 1'b1;
        wrap_n = at_end;
        count_n = at_end ? (dir ? MAXC : '0) : dir ? count - COUNT_W'(1) : count + COUNT_W'(1);
`endif
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      count <= '0;
      step <= 1'b0;
      wrap <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      step <= step_n;
      wrap <= wrap_n;
    end
endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: randomized and directed checks of count_seq_ctrl against a cycle-level reference model
module tb_count_seq_ctrl;
  localparam int TD = 4;
`ifdef COUNT_SEQ_AUTO_STOP_EN
  localparam int MX = 3;
`else
  localparam int MX = 19;
`endif
  localparam int T7 = (MX >= 7) ? 7 : MX - 1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pause = 1'b0, clear = 1'b0, dir = 1'b0;
  logic [4:0] count;
  logic running, step, wrap;
  int checks = 0, errors = 0;
  int m_state = 0, m_count = 0, m_phase = 0;
  bit m_step = 0, m_wrap = 0;

  count_seq_ctrl #(.TICK_DIV(TD), .MAX_COUNT(MX)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear), .dir(dir),
    .count(count), .running(running), .step(step), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // reference model: state 0=idle 1=run 2=paused, phase = run cycles since last step
  task automatic cyc(input bit r, input bit s, input bit p, input bit c, input bit d);
    int ns, tgt;
    bit tk;
    rst = r; start = s; pause = p; clear = c; dir = d;
    @(posedge clk);
    m_step = 0;
    m_wrap = 0;
    if (r || c) begin
      m_state = 0;
      m_count = 0;
      m_phase = 0;
    end else begin
      tk = (m_state == 1) && (m_phase == TD - 1);
      ns = s ? 1 : (p && m_state == 1) ? 2 : m_state;
      if (m_state == 1) m_phase = (m_phase + 1) % TD;
      if (tk) begin
`ifdef COUNT_SEQ_AUTO_STOP_EN
        tgt = d ? 0 : MX;
        if (m_count == tgt) ns = 0;
        else begin
          m_count = m_count + (d ? -1 : 1);
          m_step = 1;
          if (m_count == tgt) begin
            m_wrap = 1;
            ns = 0;
          end
        end
`else
        tgt = d ? 0 : MX;
        m_wrap = (m_count == tgt);
        m_count = d ? (m_count + MX) % (MX + 1) : (m_count + 1) % (MX + 1);
        m_step = 1;
`endif
      end
      m_state = ns;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 0);
      checks++;
      if ({count, running, step, wrap} !== 8'b0) begin
        errors++;
        $display("FAIL reset count=%0d run=%0b step=%0b wrap=%0b expected all 0", count, running, step, wrap);
      end
    end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 0, 0);
      checks++;
      if ({count, running, step, wrap} !== 8'b0) begin
        errors++;
        $display("FAIL reset_idle count=%0d run=%0b step=%0b wrap=%0b expected all 0", count, running, step, wrap);
      end
    end
  endtask

  task automatic test_up_wrap();
    int steps = 0, wraps = 0;
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      cyc(0, 0, 0, 0, 0);
      steps += step;
      wraps += wrap;
      checks++;
      if ({count, running, step, wrap} !== {5'(m_count), m_state == 1, m_step, m_wrap}) begin
        errors++;
        $display("FAIL up_wrap cyc=%0d count=%0d run=%0b step=%0b wrap=%0b expected %0d %0b %0b %0b",
                 i, count, running, step, wrap, m_count, m_state == 1, m_step, m_wrap);
      end
    end
`ifndef COUNT_SEQ_AUTO_STOP_EN
    checks++;
    if (steps != 20 || wraps != 1 || count !== 5'd0) begin
      errors++;
      $display("FAIL up_wrap_totals steps=%0d wraps=%0d count=%0d expected 20 1 0", steps, wraps, count);
    end
`endif
  endtask

  task automatic wait_step(input string nm, input bit d);
    int n = 0;
    while (n < 3 * TD && !step) begin
      cyc(0, 0, 0, 0, d);
      n++;
    end
    if (!step) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout no step within %0d cycles", nm, 3 * TD);
    end
  endtask

  task automatic test_down_wrap();
    cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 1);
    wait_step("down_first", 1);
    checks++;
    if (count !== 5'(MX) || wrap !== 1'b1) begin
      errors++;
      $display("FAIL down_first count=%0d wrap=%0b expected %0d 1", count, wrap, MX);
    end
    cyc(0, 0, 0, 0, 1);
    wait_step("down_second", 1);
    checks++;
    if (count !== 5'(MX - 1) || wrap !== 1'b0) begin
      errors++;
      $display("FAIL down_second count=%0d wrap=%0b expected %0d 0", count, wrap, MX - 1);
    end
  endtask

  task automatic test_pause();
    logic [4:0] held;
    int n = 0;
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    wait_step("pause_prestep", 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    held = count;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0);
      checks++;
      if (count !== held || step !== 1'b0 || running !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold count=%0d step=%0b run=%0b expected %0d 0 0", count, step, running, held);
      end
    end
    cyc(0, 1, 0, 0, 0);
    while (n < 10 && !step) begin
      cyc(0, 0, 0, 0, 0);
      n++;
    end
    checks++;
    if (n != 2 || count !== held + 5'd1) begin
      errors++;
      $display("FAIL resume_latency cycles=%0d count=%0d expected 2 %0d", n, count, held + 5'd1);
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 1, 0, 0);
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL start_pause running=%0b expected 1", running);
    end
    while (n < 20 * TD && count !== 5'(T7)) begin
      cyc(0, 0, 0, 0, 0);
      n++;
    end
    cyc(0, 1, 0, 1, 0);
    checks++;
    if (count !== 5'd0 || running !== 1'b0 || step !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL clear_start count=%0d run=%0b step=%0b wrap=%0b expected 0 0 0 0", count, running, step, wrap);
    end
    for (int i = 0; i < 2 * TD; i++) begin
      cyc(0, 0, 0, 0, 0);
      checks++;
      if (count !== 5'd0 || running !== 1'b0) begin
        errors++;
        $display("FAIL clear_idle count=%0d run=%0b expected 0 0", count, running);
      end
    end
  endtask

`ifdef COUNT_SEQ_AUTO_STOP_EN
  task automatic test_auto_stop();
    int n = 0;
    bit moved = 0;
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    while (n < 10 * TD && running) begin
      cyc(0, 0, 0, 0, 0);
      n++;
    end
    checks++;
    if (count !== 5'd3 || wrap !== 1'b1 || step !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL auto_stop count=%0d wrap=%0b step=%0b run=%0b expected 3 1 1 0", count, wrap, step, running);
    end
    cyc(0, 1, 0, 0, 0);
    n = 0;
    while (n < 3 * TD && running) begin
      cyc(0, 0, 0, 0, 0);
      moved |= step | wrap;
      n++;
    end
    checks++;
    if (n != TD || moved || count !== 5'd3) begin
      errors++;
      $display("FAIL auto_restart cycles=%0d moved=%0b count=%0d expected %0d 0 3", n, moved, count, TD);
    end
    cyc(0, 1, 0, 0, 1);
    wait_step("auto_reverse", 1);
    checks++;
    if (count !== 5'd2 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL auto_reverse count=%0d wrap=%0b expected 2 0", count, wrap);
    end
  endtask
`endif

  task automatic test_random();
    bit r, s, p, c, d;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(99) < 2);
      s = ($urandom_range(99) < 6);
      p = ($urandom_range(99) < 6);
      c = ($urandom_range(99) < 2);
      d = ($urandom_range(99) < 40);
      cyc(r, s, p, c, d);
      checks++;
      if ({count, running, step, wrap} !== {5'(m_count), m_state == 1, m_step, m_wrap}) begin
        errors++;
        $display("FAIL random cyc=%0d count=%0d run=%0b step=%0b wrap=%0b expected %0d %0b %0b %0b",
                 i, count, running, step, wrap, m_count, m_state == 1, m_step, m_wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
`ifndef COUNT_SEQ_AUTO_STOP_EN
    test_down_wrap();
`endif
    test_pause();
    test_simultaneous();
`ifdef COUNT_SEQ_AUTO_STOP_EN
    test_auto_stop();
`endif
    cyc(1, 0, 0, 0, 0);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
